// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// MC_JUMP_EN adds the j instruction (JUMP state); otherwise 000010 decodes as illegal.
package mc_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned CNT_W    = 8;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic       SRC_A_PC     = 1'b0;
   localparam logic       SRC_A_REG    = 1'b1;
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU  = 2'b00;
   localparam logic [1:0] PC_SRC_OUT  = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
      S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
   } state_e;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       mem_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       retire;
   } ctrl_t;

   // Moore control word for each state; HALT and unlisted states drive nothing.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_op    = ALU_ADD;
            c.pc_source = PC_SRC_ALU;
         end
         S_DECODE: begin
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_IMM_SH;
            c.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_REG;
            c.alu_op    = ALU_FUNCT;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_WB_R: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         S_WB_I: begin
            c.reg_write = 1'b1;
            c.retire    = 1'b1;
         end
         S_MEM_RD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_WB_MEM: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.retire     = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_req   = 1'b1;
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = SRC_A_REG;
            c.alu_src_b     = SRC_B_REG;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PC_SRC_OUT;
            c.retire        = 1'b1;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PC_SRC_JUMP;
            c.retire    = 1'b1;
         end
`endif
         default: ;
      endcase
      return c;
   endfunction

   // Opcode to first post-decode state; anything unsupported halts.
   function automatic state_e decode_op(input logic [OPCODE_W-1:0] op);
      state_e s;
      case (op)
         OP_RTYPE:     s = S_EXEC_R;
         OP_LW, OP_SW: s = S_MEM_ADDR;
         OP_BEQ:       s = S_BRANCH;
         OP_ADDI:      s = S_EXEC_I;
`ifdef MC_JUMP_EN
         OP_J:         s = S_JUMP;
`endif
         default:      s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts stalled request cycles and flags expiry on the WAIT_MAX-th one.
module mc_wait_timer
   import mc_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Independent of clr so the sequencer can feed state changes back into clr.
   assign expire_c = en && (cnt_q == CNT_W'(WAIT_MAX - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer with req/ack memory handshake and bus-error watchdog.
// Define MC_JUMP_EN to support the j instruction.
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned OP_W     = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic            iord,
   output logic            mem_write,
   output logic            ir_write,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic [1:0]      pc_source,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            retire,
   output logic            illegal,
   output logic            bus_err
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d, ctrl_c;
   logic   illegal_q, illegal_d;
   logic   bus_err_q, bus_err_d;
   logic   is_store_q, is_store_d;
   logic   ack_v_c, expire_c, fetch_ack_c, store_ack_c;
   logic   zero_unused;

   // The branch decision is made in the datapath from pc_write_cond and zero.
   assign zero_unused = zero;

   // An ack only counts while a request is actually on the bus.
   assign ack_v_c = mem_ack & ctrl_q.mem_req & ~reset;

   mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (ack_v_c | (state_d != state_q)),
      .en       (ctrl_q.mem_req & ~ack_v_c),
      .expire_c (expire_c)
   );

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      is_store_d = is_store_q;
      unique case (state_q)
         S_FETCH: begin
            if (expire_c) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else if (ack_v_c) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d    = decode_op(OPCODE_W'(opcode));
            is_store_d = (OPCODE_W'(opcode) == OP_SW);
            if (state_d == S_HALT) illegal_d = 1'b1;
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD, S_MEM_WR: begin
            if (expire_c) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else if (ack_v_c) begin
               state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end
         end
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
      ctrl_d = state_ctrl(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         ctrl_q     <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
         is_store_q <= is_store_d;
      end
   end

   // Reset masks everything so an aborted instruction issues no writes in the reset cycle.
   assign ctrl_c      = reset ? '0 : ctrl_q;
   assign fetch_ack_c = (state_q == S_FETCH) && ack_v_c;
   assign store_ack_c = (state_q == S_MEM_WR) && ack_v_c;

   assign mem_req       = ctrl_c.mem_req;
   assign iord          = ctrl_c.iord;
   assign mem_write     = ctrl_c.mem_write;
   assign ir_write      = fetch_ack_c;
   assign pc_write      = ctrl_c.pc_write | fetch_ack_c;
   assign pc_write_cond = ctrl_c.pc_write_cond;
   assign pc_source     = ctrl_c.pc_source;
   assign alu_src_a     = ctrl_c.alu_src_a;
   assign alu_src_b     = ctrl_c.alu_src_b;
   assign alu_op        = ctrl_c.alu_op;
   assign reg_dst       = ctrl_c.reg_dst;
   assign mem_to_reg    = ctrl_c.mem_to_reg;
   assign reg_write     = ctrl_c.reg_write;
   assign retire        = ctrl_c.retire | store_ack_c;
   assign illegal       = illegal_q & ~reset;
   assign bus_err       = bus_err_q & ~reset;

endmodule

// File: tb/tb_mc_sequencer.sv
// Vector-table bench for mc_sequencer with a scoreboard queue and a randomized latency check.
module tb_mc_sequencer;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ack;
   logic [5:0] opcode;
   logic       mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source, alu_src_b, alu_op;
   logic       alu_src_a, reg_dst, mem_to_reg, reg_write, retire, illegal, bus_err;

   mc_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
      .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b, alu_op;
      logic       reg_dst, mem_to_reg, reg_write, retire, illegal, bus_err;
   } obs_t;

   typedef struct {
      logic       rst;
      logic       ack;
      logic [5:0] op;
      logic       z;
      obs_t       exp;
   } vec_t;

   localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
   localparam logic [5:0] ADDI = 6'h08, J = 6'h02, BAD = 6'h3F;

   vec_t vecs[$];
   obs_t sb_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   obs_t x_zero, x_fetch, x_fa, x_dec, x_exr, x_wbr, x_exi, x_wbi, x_mrd, x_wbm;
   obs_t x_mw, x_mwa, x_br, x_jmp, x_ill, x_be;

   function automatic obs_t sample_obs();
      obs_t o;
      o.mem_req = mem_req;       o.iord = iord;           o.mem_write = mem_write;
      o.ir_write = ir_write;     o.pc_write = pc_write;   o.pc_write_cond = pc_write_cond;
      o.pc_source = pc_source;   o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
      o.alu_op = alu_op;         o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
      o.reg_write = reg_write;   o.retire = retire;       o.illegal = illegal;
      o.bus_err = bus_err;
      return o;
   endfunction

   task automatic add(input logic r, input logic a, input logic [5:0] op, input logic z,
                      input obs_t e);
      vec_t v;
      v.rst = r; v.ack = a; v.op = op; v.z = z; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   // Drive one vector at negedge, push its expectation, then pop and compare once settled.
   task automatic step(input int idx, input vec_t v);
      obs_t want;
      @(negedge clk);
      reset = v.rst; mem_ack = v.ack; opcode = v.op; zero = v.z;
      sb_q.push_back(v.exp);
      #2;
      want = sb_q.pop_front();
      check_obs($sformatf("vec%0d", idx), sample_obs(), want);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; mem_ack = 1'b0; opcode = R; zero = 1'b0;

      x_zero  = '0;
      x_fetch = '0; x_fetch.mem_req = 1'b1; x_fetch.alu_src_b = 2'b01;
      x_fa    = x_fetch; x_fa.ir_write = 1'b1; x_fa.pc_write = 1'b1;
      x_dec   = '0; x_dec.alu_src_b = 2'b11;
      x_exr   = '0; x_exr.alu_src_a = 1'b1; x_exr.alu_op = 2'b10;
      x_wbr   = '0; x_wbr.reg_dst = 1'b1; x_wbr.reg_write = 1'b1; x_wbr.retire = 1'b1;
      x_exi   = '0; x_exi.alu_src_a = 1'b1; x_exi.alu_src_b = 2'b10;
      x_wbi   = '0; x_wbi.reg_write = 1'b1; x_wbi.retire = 1'b1;
      x_mrd   = '0; x_mrd.mem_req = 1'b1; x_mrd.iord = 1'b1;
      x_wbm   = x_wbi; x_wbm.mem_to_reg = 1'b1;
      x_mw    = x_mrd; x_mw.mem_write = 1'b1;
      x_mwa   = x_mw; x_mwa.retire = 1'b1;
      x_br    = '0; x_br.alu_src_a = 1'b1; x_br.alu_op = 2'b01; x_br.pc_write_cond = 1'b1;
      x_br.pc_source = 2'b01; x_br.retire = 1'b1;
      x_jmp   = '0; x_jmp.pc_write = 1'b1; x_jmp.pc_source = 2'b10; x_jmp.retire = 1'b1;
      x_ill   = '0; x_ill.illegal = 1'b1;
      x_be    = '0; x_be.bus_err = 1'b1;

      // reset for 3 cycles, then an ack before mem_req is up is ignored
      for (int i = 0; i < 3; i++) add(1, 0, R, 0, x_zero);
      add(0, 1, R, 0, x_zero);
      // R-type
      add(0, 1, R, 0, x_fa); add(0, 0, R, 0, x_dec); add(0, 0, R, 0, x_exr);
      add(0, 0, R, 0, x_wbr);
      // addi with stray acks in non-request states
      add(0, 1, ADDI, 0, x_fa); add(0, 1, ADDI, 0, x_dec); add(0, 1, ADDI, 0, x_exi);
      add(0, 1, ADDI, 0, x_wbi);
      // lw with data ack delayed 3 cycles
      add(0, 1, LW, 0, x_fa); add(0, 0, LW, 0, x_dec); add(0, 0, LW, 0, x_exi);
      for (int i = 0; i < 3; i++) add(0, 0, LW, 0, x_mrd);
      add(0, 1, LW, 0, x_mrd); add(0, 0, LW, 0, x_wbm);
      // sw with 2-cycle fetch wait and 1-cycle write wait
      add(0, 0, SW, 0, x_fetch); add(0, 0, SW, 0, x_fetch); add(0, 1, SW, 0, x_fa);
      add(0, 0, SW, 0, x_dec); add(0, 0, SW, 0, x_exi); add(0, 0, SW, 0, x_mw);
      add(0, 1, SW, 0, x_mwa);
      // beq taken and not taken
      add(0, 1, BEQ, 1, x_fa); add(0, 0, BEQ, 1, x_dec); add(0, 0, BEQ, 1, x_br);
      add(0, 1, BEQ, 0, x_fa); add(0, 0, BEQ, 0, x_dec); add(0, 0, BEQ, 0, x_br);
      // reset during write-back aborts the R-type
      add(0, 1, R, 0, x_fa); add(0, 0, R, 0, x_dec); add(0, 0, R, 0, x_exr);
      add(1, 0, R, 0, x_zero); add(0, 0, R, 0, x_zero);
      // j
      add(0, 1, J, 0, x_fa); add(0, 0, J, 0, x_dec);
`ifdef MC_JUMP_EN
      add(0, 0, J, 0, x_jmp);
`else
      add(0, 0, J, 0, x_ill); add(0, 1, J, 0, x_ill);
      add(1, 0, R, 0, x_zero); add(0, 0, R, 0, x_zero);
`endif
      // unsupported opcode halts; acks ignored; reset clears illegal
      add(0, 1, BAD, 0, x_fa); add(0, 0, BAD, 0, x_dec);
      for (int i = 0; i < 3; i++) add(0, 1, BAD, 0, x_ill);
      add(1, 0, R, 0, x_zero); add(0, 0, R, 0, x_zero);
      // ack on the 15th request cycle is still in time
      for (int i = 0; i < 14; i++) add(0, 0, R, 0, x_fetch);
      add(0, 1, R, 0, x_fa); add(0, 0, R, 0, x_dec); add(0, 0, R, 0, x_exr);
      add(0, 0, R, 0, x_wbr);
      // 15 request cycles without ack trip the bus error
      for (int i = 0; i < 15; i++) add(0, 0, R, 0, x_fetch);
      add(0, 0, R, 0, x_be); add(0, 1, R, 0, x_be); add(0, 0, R, 0, x_be);
      add(1, 0, R, 0, x_zero); add(0, 0, R, 0, x_zero);

      @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

      // addi with a random fetch-ack delay: retire must land exactly 4 cycles after it starts
      for (int t = 0; t < 3; t++) begin
         int   d;
         int   c;
         logic seen;
         d = int'($urandom_range(0, 5));
         c = 0;
         seen = 1'b0;
         while (!seen && c < 30) begin
            @(negedge clk);
            reset = 1'b0; opcode = ADDI; zero = 1'b0; mem_ack = (c >= d);
            #2;
            if (retire === 1'b1) begin
               seen = 1'b1;
               check_int($sformatf("addi_lat%0d", t), c + 1, d + 4);
               check_int($sformatf("addi_wb%0d", t), int'({reg_write, reg_dst, mem_to_reg}),
                         int'(3'b100));
            end
            c++;
         end
         if (!seen) begin
            n_total++;
            $display("FAIL addi_timeout%0d: got no retire want retire within 30 cycles", t);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
